hazard_unit: RTL and testbench
==============================

# hazard_unit

Pipeline hazard detector for the 5-stage RISC-V core. It sits directly upstream of the forwarding mux and keeps its own shadow copy of the EX/MEM/WB destination-register state. Each cycle it produces the per-operand forward selects that steer the mux. It also detects load-use hazards, which cost a one-cycle stall plus an EX bubble, and squashes IF/ID and ID/EX on a taken branch. Saturating stall and flush counters are kept for performance debug.

## Interface
Parameters:
- CNT_W, 16, width of the stall and flush counters

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs1  in  5  ID source register 1
- id_rs2  in  5  ID source register 2
- id_use_rs1  in  1  instruction reads rs1
- id_use_rs2  in  1  instruction reads rs2
- id_rd  in  5  ID destination register
- id_reg_write  in  1  instruction writes rd
- id_mem_read  in  1  instruction is a load
- ex_branch_taken  in  1  branch/jump resolved taken in EX this cycle
- stall  out  1  hold PC and IF/ID
- flush_if_id  out  1  squash IF/ID
- flush_id_ex  out  1  insert a bubble into ID/EX
- fwd_a_sel  out  2  operand A select for the EX instruction: 00 register file, 01 MEM ALU result, 10 WB data
- fwd_b_sel  out  2  operand B select for the EX instruction, same encoding
- stall_count  out  CNT_W  load-use stalls since reset, saturating
- flush_count  out  CNT_W  branch flushes since reset, saturating

## Operation
Shadow pipeline registers:
- EX entry: valid, rs1, rs2, rd, rw, mr
- MEM entry: valid, rd, rw, mr
- WB entry: valid, rd, rw
- All three entries advance every cycle (EX→MEM→WB).
- EX loads from the ID inputs, with valid = id_valid.
- EX loads a bubble (valid=0) when stall or flush_id_ex is high.

Forwarding, computed combinationally for each operand of the EX entry:
- If rsX==0 or EX.valid==0, select 00.
- Else if MEM.valid & MEM.rw & MEM.rd==rsX, select 01. MEM has priority.
- Else if WB.valid & WB.rw & WB.rd==rsX, select 10.
- Else select 00.

Load-use hazard:
- Fires when id_valid & EX.valid & EX.mr & EX.rd!=0 & ((id_use_rs1 & id_rs1==EX.rd) | (id_use_rs2 & id_rs2==EX.rd)).
- Response: stall=1 and flush_id_ex=1.

Taken branch:
- ex_branch_taken=1 drives flush_if_id=1 and flush_id_ex=1.
- It overrides a load-use hazard in the same cycle: stall=0, and only flush_count increments.

FSM, states RUN, STALL, FLUSH, used for bookkeeping:
- Entering RUN: no event this cycle.
- Entering STALL: a stall was issued.
- Entering FLUSH: a flush was issued.
- In STALL, the EX entry is a bubble, so a load-use hazard cannot re-fire on the same ID instruction. The bench asserts this.
- A stall is never longer than one cycle.
- Transitions are evaluated every cycle; any state can go to any state.

Counters:
- Increment by 1 per stall or flush cycle.
- Hold at all-ones.

## Timing
- Reset values: all shadow valids 0, state RUN, counters 0. With valids clear, stall=0, flush_if_id=0, flush_id_ex=0, fwd_a_sel=fwd_b_sel=00.
- rst asserted mid-operation clears everything on the next edge, with no partial drain.
- Forward selects and stall/flush are combinational from the current shadow state and ID inputs, with zero latency. Shadow state updates on the clk edge.
- Load-use sequence:
  - Cycle N: load in EX, dependent in ID, stall=1.
  - Cycle N+1: load in MEM, EX bubble, dependent held in ID, stall=0.
  - Cycle N+2: dependent in EX, load in WB, fwd sel = 10.
- Branch: flush outputs are asserted in the cycle ex_branch_taken is high. The next cycle's EX entry is a bubble.
- The x0 destination never forwards and never stalls.

## Structure
- Package hazard_pkg holds:
  - fwd_sel_t: FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10
  - hz_state_t: RUN, STALL, FLUSH
  - REG_ZERO=5'd0
- One sub-module, hazard_fwd_cmp. It is the per-operand MEM/WB priority comparator and is instantiated twice, once for A and once for B.

## Test plan
- add x5 in EX, then sub x6,x5,x1 → MEM match; next cycle fwd_a_sel=01, stall=0.
- lw x7 in EX, ID add x8,x7,x7 → stall=1 and flush_id_ex=1 for exactly 1 cycle; two cycles later fwd_a_sel=fwd_b_sel=10; stall_count=1.
- MEM and WB both writing x9, EX reading x9 → fwd_a_sel=01 (MEM wins).
- lw x0 followed by a consumer of x0 → no stall, fwd_a_sel=00.
- ex_branch_taken=1 in the same cycle as a load-use hazard → stall=0, flush_if_id=flush_id_ex=1, flush_count+1, stall_count unchanged.
- Force stall_count to all-ones, then issue another stall → count holds. Assert rst mid-stall → next cycle all outputs and counters are 0, state RUN.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the hazard detector: forward-select encoding, bookkeeping states
// and the shadow pipeline entry layouts.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        STALL = 2'b01,
        FLUSH = 2'b10
    } hz_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic       vld;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
    } ex_ent_t;

    typedef struct packed {
        logic       vld;
        logic [4:0] rd;
        logic       rw;
    } mem_ent_t;

    typedef struct packed {
        logic       vld;
        logic [4:0] rd;
        logic       rw;
    } wb_ent_t;

endpackage

// File: rtl/hazard_fwd_cmp.sv
// Per-operand forward select: MEM writer beats WB writer, x0 and empty EX never forward.
// Purely combinational, zero latency, no flow control.
module hazard_fwd_cmp
    import hazard_pkg::*;
(
    input  logic       ex_vld,
    input  logic [4:0] rs,
    input  logic       mem_vld,
    input  logic       mem_rw,
    input  logic [4:0] mem_rd,
    input  logic       wb_vld,
    input  logic       wb_rw,
    input  logic [4:0] wb_rd,
    output logic [1:0] sel
);

    always_comb begin
        sel = FWD_RF;
        if (ex_vld && (rs != REG_ZERO)) begin
            if (mem_vld && mem_rw && (mem_rd == rs)) begin
                sel = FWD_MEM;
            end else if (wb_vld && wb_rw && (wb_rd == rs)) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Hazard detector with shadow EX/MEM/WB state: forward selects, load-use stall, branch flush.
// Outputs are combinational (zero latency); shadow state and counters update on the clk edge.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             ex_branch_taken,
    output logic             stall,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    ex_ent_t          ex_q, ex_d;
    mem_ent_t         mem_q, mem_d;
    wb_ent_t          wb_q, wb_d;
    hz_state_t        state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             load_use;

    // The STALL qualifier backs up the EX bubble: a held ID instruction can never re-stall.
    always_comb begin
        load_use = id_valid && ex_q.vld && ex_q.mr && (ex_q.rd != REG_ZERO)
                   && (state_q != STALL)
                   && ((id_use_rs1 && (id_rs1 == ex_q.rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_q.rd)));
    end

    always_comb begin
        stall       = load_use && !ex_branch_taken;
        flush_if_id = ex_branch_taken;
        flush_id_ex = load_use || ex_branch_taken;
    end

    always_comb begin
        ex_d     = '0;
        ex_d.vld = id_valid;
        ex_d.rs1 = id_rs1;
        ex_d.rs2 = id_rs2;
        ex_d.rd  = id_rd;
        ex_d.rw  = id_reg_write;
        ex_d.mr  = id_mem_read;
        if (stall || flush_id_ex) begin
            ex_d = '0;
        end

        mem_d     = '0;
        mem_d.vld = ex_q.vld;
        mem_d.rd  = ex_q.rd;
        mem_d.rw  = ex_q.rw;

        wb_d     = '0;
        wb_d.vld = mem_q.vld;
        wb_d.rd  = mem_q.rd;
        wb_d.rw  = mem_q.rw;
    end

    always_comb begin
        state_d = RUN;
        if (ex_branch_taken) begin
            state_d = FLUSH;
        end else if (stall) begin
            state_d = STALL;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (ex_branch_taken && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            state_q     <= RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    hazard_fwd_cmp u_fwd_a (
        .ex_vld  (ex_q.vld),
        .rs      (ex_q.rs1),
        .mem_vld (mem_q.vld),
        .mem_rw  (mem_q.rw),
        .mem_rd  (mem_q.rd),
        .wb_vld  (wb_q.vld),
        .wb_rw   (wb_q.rw),
        .wb_rd   (wb_q.rd),
        .sel     (fwd_a_sel)
    );

    hazard_fwd_cmp u_fwd_b (
        .ex_vld  (ex_q.vld),
        .rs      (ex_q.rs2),
        .mem_vld (mem_q.vld),
        .mem_rw  (mem_q.rw),
        .mem_rd  (mem_q.rd),
        .wb_vld  (wb_q.vld),
        .wb_rw   (wb_q.rw),
        .wb_rd   (wb_q.rd),
        .sel     (fwd_b_sel)
    );

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: a stage-array pipeline model predicts every cycle's
// outputs, and a negedge monitor pops and compares them against the DUT.
module tb_hazard_unit;
    import hazard_pkg::*;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_mem_read;
    logic [4:0]    id_rs1, id_rs2, id_rd;
    logic          ex_branch_taken;
    logic          stall, flush_if_id, flush_id_ex;
    logic [1:0]    fwd_a_sel, fwd_b_sel;
    logic [CW-1:0] stall_count, flush_count;

    always #5 clk = ~clk;

    hazard_unit #(.CNT_W(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .id_rd           (id_rd),
        .id_reg_write    (id_reg_write),
        .id_mem_read     (id_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .stall           (stall),
        .flush_if_id     (flush_if_id),
        .flush_id_ex     (flush_id_ex),
        .fwd_a_sel       (fwd_a_sel),
        .fwd_b_sel       (fwd_b_sel),
        .stall_count     (stall_count),
        .flush_count     (flush_count)
    );

    typedef struct {
        bit       v;
        bit [4:0] rs1, rs2, rd;
        bit       u1, u2, rw, mr;
    } ins_t;

    typedef struct {
        bit       chk;
        bit       st, fi, fe;
        bit [1:0] fa, fb;
        int       sc, fc;
        bit [1:0] state;
    } exp_t;

    exp_t     sbq[$];
    ins_t     pipe[3];           // 0 = EX, 1 = MEM, 2 = WB
    int       m_sc, m_fc;
    bit [1:0] m_state;
    bit       m_stall_last;
    bit       chk_en  = 1'b0;
    bit       started = 1'b0;
    bit       done    = 1'b0;
    int       checks   = 0;
    int       failures = 0;

    function automatic ins_t mk(bit v, bit [4:0] rs1, bit [4:0] rs2, bit u1, bit u2,
                                bit [4:0] rd, bit rw, bit mr);
        ins_t i;
        i.v = v; i.rs1 = rs1; i.rs2 = rs2; i.u1 = u1; i.u2 = u2;
        i.rd = rd; i.rw = rw; i.mr = mr;
        return i;
    endfunction

    // Youngest older writer of rs wins; x0 or an empty EX reads the register file.
    function automatic bit [1:0] m_fwd(bit [4:0] rs);
        if (rs == 5'd0 || !pipe[0].v) return 2'b00;
        for (int k = 1; k <= 2; k++) begin
            if (pipe[k].v && pipe[k].rw && pipe[k].rd == rs) return (k == 1) ? 2'b01 : 2'b10;
        end
        return 2'b00;
    endfunction

    task automatic cyc(input ins_t id, input bit br, input bit r);
        exp_t e;
        bit   lu;
        ins_t bub;
        bub = mk(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst             = r;
        id_valid        = id.v;
        id_rs1          = id.rs1;
        id_rs2          = id.rs2;
        id_use_rs1      = id.u1;
        id_use_rs2      = id.u2;
        id_rd           = id.rd;
        id_reg_write    = id.rw;
        id_mem_read     = id.mr;
        ex_branch_taken = br;
        lu = id.v && pipe[0].v && pipe[0].mr && pipe[0].rd != 5'd0 &&
             ((id.u1 && id.rs1 == pipe[0].rd) || (id.u2 && id.rs2 == pipe[0].rd));
        e.chk   = chk_en;
        e.st    = lu && !br;
        e.fi    = br;
        e.fe    = lu || br;
        e.fa    = m_fwd(pipe[0].rs1);
        e.fb    = m_fwd(pipe[0].rs2);
        e.sc    = m_sc;
        e.fc    = m_fc;
        e.state = m_state;
        sbq.push_back(e);
        m_stall_last = e.st;
        if (r) begin
            for (int k = 0; k < 3; k++) pipe[k] = bub;
            m_sc = 0; m_fc = 0; m_state = 2'd0;
        end else begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = (lu || br) ? bub : id;
            if (e.st && m_sc < CMAX) m_sc++;
            if (br && m_fc < CMAX) m_fc++;
            m_state = br ? 2'd2 : (e.st ? 2'd1 : 2'd0);
        end
    endtask

    // Issue an instruction from ID, re-presenting it for one cycle if it was stalled.
    task automatic send(input ins_t id);
        cyc(id, 0, 0);
        if (m_stall_last) cyc(id, 0, 0);
    endtask

    initial begin : monitor
        exp_t     e;
        bit       prev_stall = 1'b0;
        logic [1:0] st_a;
        forever begin
            @(negedge clk);
            if (sbq.size() == 0) begin
                if (started && !done) begin
                    checks++; failures++;
                    $display("FAIL sb_empty: no expected entry at t=%0t", $time);
                end
            end else begin
                e = sbq.pop_front();
                started = 1'b1;
                if (e.chk) begin
                    st_a = dut.state_q;
                    checks++;
                    if (stall !== e.st || flush_if_id !== e.fi || flush_id_ex !== e.fe ||
                        fwd_a_sel !== e.fa || fwd_b_sel !== e.fb ||
                        int'(stall_count) != e.sc || int'(flush_count) != e.fc ||
                        st_a !== e.state) begin
                        failures++;
                        $display("FAIL outputs t=%0t act st%b fi%b fe%b fa%b fb%b sc%0d fc%0d s%0d exp st%b fi%b fe%b fa%b fb%b sc%0d fc%0d s%0d",
                                 $time, stall, flush_if_id, flush_id_ex, fwd_a_sel, fwd_b_sel,
                                 stall_count, flush_count, st_a, e.st, e.fi, e.fe, e.fa, e.fb,
                                 e.sc, e.fc, e.state);
                    end
                    if (prev_stall) begin
                        checks++;
                        if (stall !== 1'b0) begin
                            failures++;
                            $display("FAIL stall_len t=%0t act stall=%b exp stall=0", $time, stall);
                        end
                    end
                end
                prev_stall = (stall === 1'b1);
            end
        end
    end

    initial begin : driver
        ins_t nop, id;
        bit   br, r;
        nop = mk(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        id_rd = 0; id_reg_write = 0; id_mem_read = 0; ex_branch_taken = 0;
        m_sc = 0; m_fc = 0; m_state = 0;
        for (int k = 0; k < 3; k++) pipe[k] = nop;

        cyc(nop, 0, 1);
        chk_en = 1'b1;
        cyc(nop, 0, 1);
        cyc(nop, 0, 0);
        cyc(nop, 0, 0);

        // add x5 ; sub x6,x5,x1 -> MEM forward on A
        send(mk(1, 1, 2, 1, 1, 5, 1, 0));
        send(mk(1, 5, 1, 1, 1, 6, 1, 0));
        repeat (3) cyc(nop, 0, 0);

        // lw x7 ; add x8,x7,x7 -> one stall then WB forward on both
        send(mk(1, 2, 0, 1, 0, 7, 1, 1));
        send(mk(1, 7, 7, 1, 1, 8, 1, 0));
        repeat (3) cyc(nop, 0, 0);

        // two writers of x9, MEM must win
        send(mk(1, 1, 1, 1, 1, 9, 1, 0));
        send(mk(1, 2, 2, 1, 1, 9, 1, 0));
        send(mk(1, 9, 9, 1, 1, 10, 1, 0));
        repeat (3) cyc(nop, 0, 0);

        // lw x0 ; consumer of x0
        send(mk(1, 1, 0, 1, 0, 0, 1, 1));
        send(mk(1, 0, 0, 1, 1, 11, 1, 0));
        repeat (3) cyc(nop, 0, 0);

        // branch in the same cycle as a load-use hazard
        send(mk(1, 1, 0, 1, 0, 12, 1, 1));
        cyc(mk(1, 12, 3, 1, 1, 13, 1, 0), 1, 0);
        repeat (3) cyc(nop, 0, 0);

        // drive the stall counter past saturation
        for (int i = 0; i < CMAX + 3; i++) begin
            send(mk(1, 1, 0, 1, 0, 3, 1, 1));
            send(mk(1, 3, 2, 1, 1, 4, 1, 0));
        end
        cyc(nop, 0, 0);

        // reset while stalling
        send(mk(1, 1, 0, 1, 0, 3, 1, 1));
        cyc(mk(1, 3, 2, 1, 1, 4, 1, 0), 0, 1);
        cyc(nop, 0, 0);
        cyc(nop, 0, 0);

        id = nop;
        for (int n = 0; n < 3000; n++) begin
            br = ($urandom_range(0, 7) == 0);
            r  = ($urandom_range(0, 299) == 0);
            if (!m_stall_last) begin
                id = mk($urandom_range(0, 7) != 0, 5'($urandom_range(0, 5)),
                        5'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), 5'($urandom_range(0, 5)),
                        $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
            end
            cyc(id, br, r);
        end

        done = 1'b1;
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
